// File: rtl/mdr_seq_core.sv
// Sequential multiply / divide / square-root engine with a start/load operand handshake.
// A single add/subtract datapath is iterated one result bit per cycle.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_X | X operand requested
// LOAD_Y | Y operand requested
// RUN    | one result bit per cycle
// FIX    | sign / remainder correction
// DONE   | outputs valid, waiting for start
module mdr_seq_core #(
  parameter int DW = 16,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load,
  input  logic [1:0]      op,
  input  logic            sgn,
  input  logic [DW-1:0]   data,
  output logic            load_x,
  output logic            load_y,
  output logic            busy,
  output logic            ready,
  output logic            error,
  output logic [2*DW-1:0] result,
  output logic [DW-1:0]   remainder
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_X = 3'd1;
  localparam logic [2:0] S_LOAD_Y = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FIX    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [CW-1:0] CNT_LAST_MD   = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_LAST_SQRT = CW'(DW / 2 - 1);

  logic [2:0]    state;
  logic [1:0]    op_q;
  logic          sgn_q;
  logic [DW-1:0] x_q;
  logic [DW+1:0] r_q;
  logic [DW-1:0] q_q;
  logic [DW-1:0] m_q;
  logic [CW-1:0] cnt;
  logic          x_neg_q;
  logic          y_neg_q;

  logic          last_load;
  logic          chk_err;
  logic [DW-1:0] x_src;
  logic          x_neg_c;
  logic          y_neg_c;
  logic [DW-1:0] x_mag;
  logic [DW-1:0] y_mag;
  logic [CW-1:0] cnt_last;
  logic [DW+1:0] add_a;
  logic [DW+1:0] add_b;
  logic          add_sub;
  logic [DW+1:0] sum;
  logic [2*DW-1:0] prod;
  logic [DW:0]   quo_s;

  assign load_x = (state == S_LOAD_X);
  assign load_y = (state == S_LOAD_Y);
  assign busy   = (state == S_LOAD_X) || (state == S_LOAD_Y) || (state == S_RUN) || (state == S_FIX);
  assign ready  = (state == S_DONE);

  assign last_load = load && (((state == S_LOAD_X) && (op_q == OP_SQRT)) || (state == S_LOAD_Y));
  assign chk_err   = (op_q == OP_ILL) || ((op_q == OP_DIV) && (data == '0)) ||
                     ((op_q == OP_SQRT) && sgn_q && data[DW-1]);

  assign x_src   = (state == S_LOAD_X) ? data : x_q;
  assign x_neg_c = sgn_q & x_src[DW-1];
  assign y_neg_c = sgn_q & data[DW-1];
  assign x_mag   = x_neg_c ? -x_src : x_src;
  assign y_mag   = y_neg_c ? -data : data;
  assign cnt_last = (op_q == OP_SQRT) ? CNT_LAST_SQRT : CNT_LAST_MD;

  // Shared adder: mult accumulates, div trial-subtracts, sqrt adds or subtracts on the sign of R.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (op_q)
      OP_MUL: begin
        add_a = r_q;
        add_b = q_q[0] ? {2'b00, m_q} : '0;
      end
      OP_DIV: begin
        add_a   = {1'b0, r_q[DW-1:0], q_q[DW-1]};
        add_b   = {2'b00, m_q};
        add_sub = 1'b1;
      end
      OP_SQRT: begin
        if (state == S_FIX) begin
          add_a = r_q;
          add_b = {1'b0, m_q, 1'b1};
        end else begin
          add_a   = {r_q[DW-1:0], q_q[DW-1:DW-2]};
          add_b   = {2'b00, m_q[DW-3:0], r_q[DW+1], 1'b1};
          add_sub = ~r_q[DW+1];
        end
      end
      default: ;
    endcase
    sum = add_sub ? (add_a - add_b) : (add_a + add_b);
  end

  assign prod  = {r_q[DW-1:0], q_q};
  assign quo_s = (x_neg_q ^ y_neg_q) ? -{1'b0, q_q} : {1'b0, q_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      x_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt       <= '0;
      x_neg_q   <= 1'b0;
      y_neg_q   <= 1'b0;
      error     <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q  <= op;
            sgn_q <= sgn;
            error <= 1'b0;
            state <= S_LOAD_X;
          end
        end
        S_LOAD_X, S_LOAD_Y: begin
          if (load && (state == S_LOAD_X)) begin
            x_q <= data;
            if (op_q != OP_SQRT) state <= S_LOAD_Y;
          end
          if (last_load) begin
            if (chk_err) begin
              error     <= 1'b1;
              result    <= '0;
              remainder <= '0;
              state     <= S_DONE;
            end else begin
              x_neg_q <= x_neg_c;
              y_neg_q <= (op_q == OP_SQRT) ? 1'b0 : y_neg_c;
              r_q     <= '0;
              cnt     <= '0;
              case (op_q)
                OP_MUL:  begin q_q <= y_mag; m_q <= x_mag; end
                OP_DIV:  begin q_q <= x_mag; m_q <= y_mag; end
                default: begin q_q <= x_src; m_q <= '0;    end
              endcase
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          case (op_q)
            OP_MUL: begin
              r_q <= {1'b0, sum[DW+1:1]};
              q_q <= {sum[0], q_q[DW-1:1]};
            end
            OP_DIV: begin
              r_q <= sum[DW+1] ? add_a : sum;
              q_q <= {q_q[DW-2:0], ~sum[DW+1]};
            end
            default: begin
              r_q <= sum;
              q_q <= {q_q[DW-3:0], 2'b00};
              m_q <= {m_q[DW-2:0], ~sum[DW+1]};
            end
          endcase
          cnt <= cnt + 1'b1;
          if (cnt == cnt_last) state <= S_FIX;
        end
        S_FIX: begin
          case (op_q)
            OP_MUL: begin
              result    <= (x_neg_q ^ y_neg_q) ? -prod : prod;
              remainder <= '0;
            end
            OP_DIV: begin
              // Quotient is DW+1 bits signed so that -2^(DW-1) / -1 stays positive.
              result    <= sgn_q ? {{(DW-1){quo_s[DW]}}, quo_s} : {{DW{1'b0}}, q_q};
              remainder <= x_neg_q ? -r_q[DW-1:0] : r_q[DW-1:0];
            end
            default: begin
              result    <= {{(2*DW-DW/2){1'b0}}, m_q[DW/2-1:0]};
              remainder <= r_q[DW+1] ? sum[DW-1:0] : r_q[DW-1:0];
            end
          endcase
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_seq_core.sv
// Directed + random bench for mdr_seq_core (DW=16); expectations are queued when an
// operation is issued and popped when ready rises.
module tb_mdr_seq_core;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            load = 1'b0;
  logic [1:0]      op = 2'b00;
  logic            sgn = 1'b0;
  logic [DW-1:0]   data = '0;
  logic            load_x, load_y, busy, ready, error;
  logic [2*DW-1:0] result;
  logic [DW-1:0]   remainder;

  mdr_seq_core #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .op(op), .sgn(sgn), .data(data),
    .load_x(load_x), .load_y(load_y), .busy(busy), .ready(ready), .error(error),
    .result(result), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [15:0] rem;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   ly_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model built on native integer arithmetic.
  task automatic model(input logic [1:0] o, input logic s, input logic [15:0] x, input logic [15:0] y,
                       output logic [31:0] r, output logic [15:0] rm, output logic e);
    longint a, b, q;
    a = s ? longint'($signed(x)) : longint'(x);
    b = s ? longint'($signed(y)) : longint'(y);
    r = '0; rm = '0; e = 1'b0;
    case (o)
      2'b00: r = 32'(a * b);
      2'b01: if (b == 0) e = 1'b1; else begin r = 32'(a / b); rm = 16'(a % b); end
      2'b10: if (a < 0) e = 1'b1;
             else begin
               q = 0;
               while ((q + 1) * (q + 1) <= a) q++;
               r = 32'(q); rm = 16'(a - q * q);
             end
      default: e = 1'b1;
    endcase
  endtask

  // Latency is the index j of the first edge k+j (k = final load edge) that samples ready high.
  task automatic run_op(input logic [1:0] o, input logic s, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] er, input logic [15:0] erm, input logic ee, input bit poke);
    exp_t e;
    int j;
    e.res = er; e.rem = erm; e.err = ee;
    e.lat = ee ? 1 : ((o == 2'b10) ? DW/2 + 2 : DW + 2);
    sb.push_back(e);
    ly_seen = 1'b0;
    @(negedge clk); start = 1'b1; op = o; sgn = s;
    @(negedge clk); start = 1'b0; op = ~o; sgn = ~s;
    chk("load_x_req", load_x, 1'b1);
    if (load_y) ly_seen = 1'b1;
    load = 1'b1; data = x;
    if (o != 2'b10) begin
      @(negedge clk);
      chk("load_y_req", load_y, 1'b1);
      data = y;
    end
    @(posedge clk);
    j = 0;
    do begin
      @(negedge clk);
      load = 1'b0; data = 16'($urandom);
      j++;
      if (load_y) ly_seen = 1'b1;
      if (poke) begin start = (j == 4); op = 2'b11; end
    end while (!ready && j < 100);
    start = 1'b0;
    e = sb.pop_front();
    chk("latency", 64'(j), 64'(e.lat));
    chk("result", result, e.res);
    chk("remainder", remainder, e.rem);
    chk("error", error, e.err);
    chk("busy_done", busy, 1'b0);
    if (o == 2'b10) chk("sqrt_no_load_y", ly_seen, 1'b0);
  endtask

  task automatic run_model(input logic [1:0] o, input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] r;
    logic [15:0] rm;
    logic e;
    model(o, s, x, y, r, rm, e);
    run_op(o, s, x, y, r, rm, e, 1'b0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic        rs;
    logic [15:0] rx, ry;

    #12;
    chk("reset_outputs", {load_x, load_y, busy, ready, error, result, remainder}, '0);
    @(negedge clk); rst = 1'b1;

    run_op(2'b00, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 16'h0000, 1'b0, 1'b0);
    run_op(2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'h0000, 1'b0, 1'b0);
    run_op(2'b01, 1'b1, 16'h8000, 16'hFFFF, 32'h00008000, 16'h0000, 1'b0, 1'b0);
    run_op(2'b01, 1'b1, 16'hFFF9, 16'h0002, 32'hFFFFFFFD, 16'hFFFF, 1'b0, 1'b0);
    run_op(2'b01, 1'b0, 16'h1234, 16'h0000, 32'h0,        16'h0000, 1'b1, 1'b0);
    run_op(2'b10, 1'b0, 16'd1000, 16'h0000, 32'd31,       16'd39,   1'b0, 1'b0);
    run_op(2'b10, 1'b0, 16'h8000, 16'h0000, 32'd181,      16'd7,    1'b0, 1'b0);
    run_op(2'b10, 1'b1, 16'h8000, 16'h0000, 32'h0,        16'h0000, 1'b1, 1'b0);
    run_op(2'b11, 1'b0, 16'h0005, 16'h0006, 32'h0,        16'h0000, 1'b1, 1'b0);
    run_op(2'b01, 1'b0, 16'd1000, 16'd7,    32'd142,      16'd6,    1'b0, 1'b0);
    run_op(2'b00, 1'b0, 16'd100,  16'd200,  32'd20000,    16'h0000, 1'b0, 1'b1);

    // Stray load while in DONE must not disturb the held outputs.
    @(negedge clk); load = 1'b1; data = 16'hABCD;
    @(negedge clk); load = 1'b0;
    chk("done_hold", {ready, busy, error, result, remainder}, {1'b1, 1'b0, 1'b0, 32'd20000, 16'h0000});

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); start = 1'b1; op = 2'b00; sgn = 1'b1;
    @(negedge clk); start = 1'b0; load = 1'b1; data = 16'd7;
    @(negedge clk); data = 16'd9;
    @(negedge clk); load = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("reset_mid_run", {load_x, load_y, busy, ready, error, result, remainder}, '0);
    @(negedge clk); rst = 1'b1;
    run_op(2'b00, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 16'h0000, 1'b0, 1'b0);

    repeat (24) begin
      ro = 2'($urandom_range(0, 2));
      rs = 1'($urandom);
      rx = 16'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_model(ro, rs, rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
